// File: rtl/hs_fifo_buf_if.sv
// ============================================================================
//  Module   : hs_fifo_buf_if
//  Brief    : Sender/receiver four-phase handshake bundle for hs_fifo_buf.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hs_fifo_buf_if #(
    parameter int WIDTH = 32
);
    logic             StoB_REQ;
    logic [WIDTH-1:0] DI;
    logic             BtoS_ACK;
    logic             BtoR_REQ;
    logic             RtoB_ACK;
    logic [WIDTH-1:0] DO;

    // master is the buffer itself; slave is the sender/receiver environment
    modport master (
        input  StoB_REQ, DI, RtoB_ACK,
        output BtoS_ACK, BtoR_REQ, DO
    );

    modport slave (
        output StoB_REQ, DI, RtoB_ACK,
        input  BtoS_ACK, BtoR_REQ, DO
    );
endinterface

`default_nettype wire

// File: rtl/hs_fifo_buf.sv
// ============================================================================
//  Module   : hs_fifo_buf
//  Brief    : Circular FIFO between a four-phase sender and a four-phase receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_fifo_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    hs_fifo_buf_if.master                     bus,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              proto_err
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } s_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2
    } r_state_t;

    s_state_t             s_state_q, s_state_d;
    r_state_t             r_state_q, r_state_d;
    logic [C_PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q,   count_d;
    logic                 avail_q,   avail_d;
    logic                 s_ack_q,   s_ack_d;
    logic                 r_req_q,   r_req_d;
    logic [WIDTH-1:0]     do_q,      do_d;
    logic                 perr_q,    perr_d;
    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    always_comb begin
        s_state_d = s_state_q;
        r_state_d = r_state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        s_ack_d   = s_ack_q;
        r_req_d   = r_req_q;
        do_d      = do_q;
        w_push    = 1'b0;
        w_pop     = 1'b0;

        // Full check uses the pre-pop count, so a same-edge pop never admits a write
        case (s_state_q)
            S_IDLE: begin
                if (bus.StoB_REQ && (count_q != C_CNT_W'(DEPTH))) begin
                    w_push    = 1'b1;
                    wr_ptr_d  = ptr_inc(wr_ptr_q);
                    s_ack_d   = 1'b1;
                    s_state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.StoB_REQ) begin
                    s_ack_d   = 1'b0;
                    s_state_d = S_IDLE;
                end
            end
            default: s_state_d = S_IDLE;
        endcase

        // avail_q lags count by one edge: this sets the two-edge write-to-request latency
        case (r_state_q)
            R_IDLE: begin
                if (avail_q) begin
                    do_d      = mem_q[rd_ptr_q];
                    r_req_d   = 1'b1;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (bus.RtoB_ACK) begin
                    w_pop     = 1'b1;
                    rd_ptr_d  = ptr_inc(rd_ptr_q);
                    r_req_d   = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!bus.RtoB_ACK) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase

        avail_d = (count_q != '0);
        perr_d  = perr_q | ((r_state_q == R_IDLE) && bus.RtoB_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_state_q <= S_IDLE;
            r_state_q <= R_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            avail_q   <= 1'b0;
            s_ack_q   <= 1'b0;
            r_req_q   <= 1'b0;
            do_q      <= '0;
            perr_q    <= 1'b0;
        end else begin
            s_state_q <= s_state_d;
            r_state_q <= r_state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            avail_q   <= avail_d;
            s_ack_q   <= s_ack_d;
            r_req_q   <= r_req_d;
            do_q      <= do_d;
            perr_q    <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= bus.DI;
        end
    end

    assign bus.BtoS_ACK = s_ack_q;
    assign bus.BtoR_REQ = r_req_q;
    assign bus.DO       = do_q;
    assign count        = count_q;
    assign proto_err    = perr_q;

endmodule

`default_nettype wire
